inst_cache: RTL and testbench
=============================

Name: inst_cache

Overview:
- Direct-mapped instruction cache sitting directly downstream of the program-counter register.
- Takes the 16-bit current PC as the fetch address and returns the 32-bit instruction.
- Drives the `hit` qualifier that the PC register uses to hold its value while a miss is serviced.
- On a miss it refills one block from instruction memory over a simple req/ready handshake, one word per beat.

Parameters:
- INDEX_W, 4, line index bits; 2**INDEX_W lines.
- OFFSET_W, 2, word-in-block bits; 2**OFFSET_W 32-bit words per block.
- TAG_W, 16-2-OFFSET_W-INDEX_W (=8), tag bits; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc  in  16  byte fetch address; pc[1:0] ignored
- flush  in  1  invalidate all lines (one-cycle pulse)
- inst  out  32  instruction at pc; valid only while hit=1
- hit  out  1  lookup hit; PC register advances only when 1
- mem_req  out  1  refill beat request
- mem_addr  out  16  byte address of requested word, word-aligned
- mem_ready  in  1  memory has mem_rdata valid for current mem_addr this cycle
- mem_rdata  in  32  refill word

Behaviour:
- Address split:
  - tag = pc[15:15-TAG_W+1]
  - idx = pc[2+OFFSET_W+INDEX_W-1 : 2+OFFSET_W]
  - off = pc[2+OFFSET_W-1:2]
- Storage: data array, tag array and valid bit per line. Valid bits are reset to 0; data and tag arrays are not reset.
- FSM states: IDLE, FILL.
- IDLE:
  - hit = valid[idx] && tag_arr[idx]==tag (combinational, same cycle as pc).
  - inst = data[idx][off].
  - When hit=0: inst is don't-care; drive 0.
  - Miss in IDLE with flush=0: latch miss_tag, miss_idx; beat counter = 0; next state FILL.
- FILL:
  - hit = 0.
  - mem_req = 1.
  - mem_addr = {miss_tag, miss_idx, beat, 2'b00}. Refill always starts at word 0 of the block, not at the critical word.
  - Each cycle with mem_ready=1: write mem_rdata to data[miss_idx][beat]; beat increments.
  - mem_ready=0: hold mem_addr and beat stable.
  - On the final beat (beat == 2**OFFSET_W-1 with mem_ready=1):
    - tag_arr[miss_idx] = miss_tag.
    - valid[miss_idx] = 1, unless a flush is pending.
    - Next state IDLE; mem_req drops the following cycle.
- Latency:
  - Hit: 0 cycles, combinational.
  - Miss with mem_ready held high: miss seen in cycle 0, beats in cycles 1..4, hit=1 in cycle 5.
  - Each mem_ready=0 cycle adds one cycle.
- pc changing during FILL: ignored. The refill completes for the latched block, then IDLE re-looks up the current pc.
- flush:
  - In IDLE: all valid bits clear at the next edge; hit forced 0 in the flush cycle; no fill is started that cycle.
  - In FILL: set flush_pending. The fill completes its memory beats (no aborted handshake). At completion all valid bits clear and the filled line stays invalid; flush_pending clears.
- Simultaneous final beat and flush: treated as flush in FILL; the line ends invalid.
- Reset, including mid-FILL:
  - state=IDLE, beat=0, flush_pending=0, all valid=0.
  - mem_req=0, mem_addr=0, hit=0, inst=0 in the cycle following reset.
  - A memory beat in progress is abandoned.
- Conflict miss (same idx, different tag): the line is overwritten; no victim handling (read-only cache).

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, adds outputs hit_count[15:0] and miss_count[15:0], both reset to 0 and saturating at 16'hFFFF:
  - hit_count increments each IDLE cycle with hit=1.
  - miss_count increments once per FILL entry.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then pc=16'h0040 with memory returning word = address, mem_ready=1 -> hit=0, FILL requests 0x0040, 0x0044, 0x0048, 0x004C on consecutive cycles; hit=1 with inst=32'h0000_0040 five cycles after the miss.
- After that fill, pc=0x0048 -> hit=1, inst=32'h0000_0048 in the same cycle; pc=0x0050 (idx 5) -> miss.
- Conflict: fill 0x0040, then pc=0x0140 (same idx 4, tag 0x01) -> refill; then pc=0x0040 -> miss again.
- mem_ready toggling 1,0,1,0... during a fill -> mem_addr holds through low cycles; fill completes after 8 cycles; data correct.
- flush pulsed during beat 2 of fill for 0x0080 -> all four beats complete; pc=0x0080 then misses again; a previously valid line 0x0040 also misses.
- rst asserted mid-FILL at beat 1 -> next cycle mem_req=0, hit=0; subsequent pc=0x0040 restarts a fill from word 0. With ICACHE_STATS_EN: hit_count=0, miss_count=0 after reset.

Source files
------------

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache placed after the PC register.
// A hit returns the instruction in the same cycle. A miss refills the whole
// block from instruction memory, one word per req/ready beat, always starting
// at word 0 of the block.
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters.
module inst_cache #(
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        hit,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  // The tag takes whatever address bits the index and offset leave over.
  localparam int TAG_W = 16 - 2 - OFFSET_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFSET_W);
  localparam logic [OFFSET_W-1:0] LAST_BEAT = {OFFSET_W{1'b1}};
  localparam logic [OFFSET_W-1:0] BEAT_ONE  = OFFSET_W'(1'b1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_r;
  logic [TAG_W-1:0]    miss_tag_r;
  logic [INDEX_W-1:0]  miss_idx_r;
  logic [OFFSET_W-1:0] beat_r;
  logic                flush_pending_r;
  logic [LINES-1:0]    valid_r;
  logic [TAG_W-1:0]    tag_arr_r [LINES];
  logic [31:0]         data_r [WORDS];

  logic [TAG_W-1:0]    tag_s;
  logic [INDEX_W-1:0]  idx_s;
  logic [OFFSET_W-1:0] off_s;
  logic                hit_s;
  logic [31:0]         inst_s;
  logic                fill_start_s;
  logic                beat_done_s;
  logic                fill_done_s;
  logic                pc_unused_s;

  // Fetch address split; the byte-in-word bits play no part in the lookup.
  assign tag_s       = pc[15 -: TAG_W];
  assign idx_s       = pc[2 + OFFSET_W +: INDEX_W];
  assign off_s       = pc[2 +: OFFSET_W];
  assign pc_unused_s = ^pc[1:0];

  // Lookup: hit only in IDLE with a matching valid line and no flush this cycle.
  always_comb begin
    hit_s  = 1'b0;
    inst_s = 32'h0000_0000;
    if ((state_r == IDLE) && !flush && valid_r[idx_s] && (tag_arr_r[idx_s] == tag_s)) begin
      hit_s  = 1'b1;
      inst_s = data_r[{idx_s, off_s}];
    end else begin
      hit_s  = 1'b0;
      inst_s = 32'h0000_0000;
    end
  end

  // A flush in IDLE suppresses the miss so no fill is launched that cycle.
  assign fill_start_s = (state_r == IDLE) && !flush && !hit_s;
  assign beat_done_s  = (state_r == FILL) && mem_ready;
  assign fill_done_s  = beat_done_s && (beat_r == LAST_BEAT);

  // Control FSM: miss capture, beat counting, valid bits and deferred flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      miss_tag_r      <= {TAG_W{1'b0}};
      miss_idx_r      <= {INDEX_W{1'b0}};
      beat_r          <= {OFFSET_W{1'b0}};
      flush_pending_r <= 1'b0;
      valid_r         <= {LINES{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (flush) begin
            valid_r <= {LINES{1'b0}};
          end else if (fill_start_s) begin
            miss_tag_r <= tag_s;
            miss_idx_r <= idx_s;
            beat_r     <= {OFFSET_W{1'b0}};
            state_r    <= FILL;
          end
        end
        FILL: begin
          if (fill_done_s) begin
            state_r         <= IDLE;
            beat_r          <= {OFFSET_W{1'b0}};
            flush_pending_r <= 1'b0;
            // A flush seen at any point of the fill leaves every line invalid,
            // including the one just written.
            if (flush_pending_r || flush) begin
              valid_r <= {LINES{1'b0}};
            end else begin
              valid_r[miss_idx_r] <= 1'b1;
            end
          end else begin
            if (mem_ready) begin
              beat_r <= beat_r + BEAT_ONE;
            end
            if (flush) begin
              flush_pending_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Storage writes: one data word per accepted beat, tag on the final beat.
  always_ff @(posedge clk) begin
    if (!rst && beat_done_s) begin
      data_r[{miss_idx_r, beat_r}] <= mem_rdata;
    end
    if (!rst && fill_done_s) begin
      tag_arr_r[miss_idx_r] <= miss_tag_r;
    end
  end

  assign hit      = hit_s;
  assign inst     = inst_s;
  assign mem_req  = (state_r == FILL);
  assign mem_addr = (state_r == FILL) ? {miss_tag_r, miss_idx_r, beat_r, 2'b00} : 16'h0000;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_r;
  logic [15:0] miss_count_r;

  // Saturating statistics: hits per IDLE cycle, misses per fill launched.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_r  <= 16'h0000;
      miss_count_r <= 16'h0000;
    end else begin
      if (hit_s && (hit_count_r != 16'hFFFF)) begin
        hit_count_r <= hit_count_r + 16'h0001;
      end
      if (fill_start_s && (miss_count_r != 16'hFFFF)) begin
        miss_count_r <= miss_count_r + 16'h0001;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed bench for inst_cache. The memory model returns
// {pat, mem_addr} for every refill word so each word is traceable to its
// address and to the fill that wrote it.
module tb_inst_cache;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic        flush;
  logic [31:0] inst;
  logic        hit;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [15:0] pat;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  inst_cache dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .flush     (flush),
    .inst      (inst),
    .hit       (hit),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory model: word content derived from its address.
  always_comb mem_rdata = {pat, mem_addr};

  // Safety net against a runaway run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Miss on block address a, four back-to-back beats, then hit on word 0.
  task automatic fill_block(input logic [15:0] a, input string tg);
    pc = a;
    mem_ready = 1'b1;
    #1;
    chk({tg, "_miss"}, {31'd0, hit}, 32'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk({tg, "_req"}, {31'd0, mem_req}, 32'd1);
      chk({tg, "_addr"}, {16'd0, mem_addr}, {16'd0, a + 16'(4 * b)});
      tick();
    end
    chk({tg, "_hit"}, {31'd0, hit}, 32'd1);
    chk({tg, "_inst"}, inst, {pat, a});
    chk({tg, "_req_drop"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    pc        = 16'h0000;
    flush     = 1'b0;
    mem_ready = 1'b0;
    pat       = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state.
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_inst", inst, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hitcnt", {16'd0, hit_count}, 32'd0);
    chk("rst_misscnt", {16'd0, miss_count}, 32'd0);
`endif

    // First fill: 0x0040, hit five cycles after the miss.
    fill_block(16'h0040, "fill40");
`ifdef ICACHE_STATS_EN
    chk("misscnt1", {16'd0, miss_count}, 32'd1);
`endif

    // Same-cycle hits in the filled block, then a miss on idx 5.
    pc = 16'h0048;
    #1;
    chk("hit48", {31'd0, hit}, 32'd1);
    chk("inst48", inst, 32'h0000_0048);
    pc = 16'h004C;
    #1;
    chk("inst4c", inst, 32'h0000_004C);
    pc = 16'h0050;
    #1;
    chk("miss50", {31'd0, hit}, 32'd0);
    chk("miss50_inst", inst, 32'd0);
    fill_block(16'h0050, "fill50");
    pc = 16'h0044;
    #1;
    chk("hit44", {31'd0, hit}, 32'd1);
    chk("inst44", inst, 32'h0000_0044);

    // Conflict: 0x0140 shares idx 4 with 0x0040 and evicts it.
    pat = 16'h0001;
    fill_block(16'h0140, "fill140");
    pc = 16'h0040;
    #1;
    chk("conf_miss40", {31'd0, hit}, 32'd0);
    pat = 16'hA5A5;
    fill_block(16'h0040, "refill40");
    pc = 16'h0148;
    #1;
    chk("conf_miss148", {31'd0, hit}, 32'd0);
    pc = 16'h0044;
    #1;
    chk("refill_inst44", inst, 32'hA5A5_0044);

    // mem_ready toggling 1,0,1,0,...: address holds through low cycles.
    pat = 16'h0C0C;
    pc = 16'h00C0;
    mem_ready = 1'b1;
    #1;
    chk("tog_miss", {31'd0, hit}, 32'd0);
    tick();
    for (int k = 1; k <= 7; k++) begin
      mem_ready = k[0];
      #1;
      chk("tog_req", {31'd0, mem_req}, 32'd1);
      chk("tog_addr", {16'd0, mem_addr}, {16'd0, 16'h00C0 + 16'(4 * (k / 2))});
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("tog_hit", {31'd0, hit}, 32'd1);
    chk("tog_inst_c0", inst, 32'h0C0C_00C0);
    pc = 16'h00CC;
    #1;
    chk("tog_inst_cc", inst, 32'h0C0C_00CC);
    pc = 16'h00C8;
    #1;
    chk("tog_inst_c8", inst, 32'h0C0C_00C8);

    // Flush during beat 2 of the fill for 0x0080.
    pat = 16'h0002;
    pc = 16'h0080;
    #1;
    chk("fl_miss", {31'd0, hit}, 32'd0);
    tick();
    chk("fl_addr0", {16'd0, mem_addr}, 32'h0080);
    tick();
    chk("fl_addr1", {16'd0, mem_addr}, 32'h0084);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_addr2", {16'd0, mem_addr}, 32'h0088);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_req3", {31'd0, mem_req}, 32'd1);
    chk("fl_addr3", {16'd0, mem_addr}, 32'h008C);
    tick();
    chk("fl_done_req", {31'd0, mem_req}, 32'd0);
    chk("fl_miss80", {31'd0, hit}, 32'd0);
    pc = 16'h0040;
    #1;
    chk("fl_miss40", {31'd0, hit}, 32'd0);

    // Reset in the middle of a fill at beat 1.
    tick();
    chk("rf_addr0", {16'd0, mem_addr}, 32'h0040);
    tick();
    chk("rf_addr1", {16'd0, mem_addr}, 32'h0044);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rf_req", {31'd0, mem_req}, 32'd0);
    chk("rf_hit", {31'd0, hit}, 32'd0);
    chk("rf_addr", {16'd0, mem_addr}, 32'd0);
    chk("rf_inst", inst, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rf_hitcnt", {16'd0, hit_count}, 32'd0);
    chk("rf_misscnt", {16'd0, miss_count}, 32'd0);
`endif
    pat = 16'h0003;
    fill_block(16'h0040, "rf_refill");

    // Flush in IDLE: hit forced low, no fill launched, line invalid after.
    flush = 1'b1;
    #1;
    chk("idle_fl_hit", {31'd0, hit}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("idle_fl_req", {31'd0, mem_req}, 32'd0);
    chk("idle_fl_miss", {31'd0, hit}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
